// File: rtl/tlul_adapter_reg_pipe.sv
// Pipelined TL-UL device adapter: A-channel requests become single-cycle register strobes, responses return on D.
// Latency: strobe in the A-accept cycle T, rdata/error sampled at the end of T+AccessLatency, d_valid from T+AccessLatency+1.
// Backpressure: a_ready drops when MaxOutstanding requests are un-acked or busy_i is high while a_valid; d_ready never gates a_ready.
//
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   tl_i / tl_o        TL-UL host request / device response
//   re_o, we_o         read / write strobes (accept cycle only)
//   addr_o             word-aligned register address
//   wdata_o, be_o      write data and byte enables, straight from the A channel
//   busy_i             register block cannot take the presented request
//   rdata_i, error_i   read data / access error, valid AccessLatency cycles after the strobe
//   outstanding_o      accepted but not yet D-acked request count

package top_pkg;
    localparam int TL_AW  = 32;
    localparam int TL_DW  = 32;
    localparam int TL_AIW = 8;
    localparam int TL_DIW = 1;
    localparam int TL_DBW = TL_DW / 8;
    localparam int TL_SZW = 2;
    localparam int TL_AUW = 16;
    localparam int TL_DUW = 16;
endpackage

package tlul_pkg;
    typedef enum logic [2:0] {
        PutFullData    = 3'h0,
        PutPartialData = 3'h1,
        Get            = 3'h4
    } tl_a_op_e;

    typedef enum logic [2:0] {
        AccessAck     = 3'h0,
        AccessAckData = 3'h1
    } tl_d_op_e;

    // Opcode fields are plain vectors so that illegal opcodes can be carried and reported.
    typedef struct packed {
        logic                         a_valid;
        logic [2:0]                   a_opcode;
        logic [2:0]                   a_param;
        logic [top_pkg::TL_SZW-1:0]   a_size;
        logic [top_pkg::TL_AIW-1:0]   a_source;
        logic [top_pkg::TL_AW-1:0]    a_address;
        logic [top_pkg::TL_DBW-1:0]   a_mask;
        logic [top_pkg::TL_DW-1:0]    a_data;
        logic [top_pkg::TL_AUW-1:0]   a_user;
        logic                         d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic                         d_valid;
        logic [2:0]                   d_opcode;
        logic [2:0]                   d_param;
        logic [top_pkg::TL_SZW-1:0]   d_size;
        logic [top_pkg::TL_AIW-1:0]   d_source;
        logic [top_pkg::TL_DIW-1:0]   d_sink;
        logic [top_pkg::TL_DW-1:0]    d_data;
        logic [top_pkg::TL_DUW-1:0]   d_user;
        logic                         d_error;
        logic                         a_ready;
    } tl_d2h_t;
endpackage

// Generic synchronous FIFO with registered storage.
// Latency: a pushed entry is visible at the head the cycle after the push.
// Backpressure: push is ignored while full; pop is ignored while empty.
//
// Ports: clk_i/rst_ni, push/push_dat, pop, pop_vld/pop_dat (head entry), full.
module fifo_sync #(
    parameter int Width = 8,
    parameter int Depth = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push,
    input  logic [Width-1:0] push_dat,
    input  logic             pop,
    output logic             pop_vld,
    output logic [Width-1:0] pop_dat,
    output logic             full
);
    localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int CntW = $clog2(Depth + 1);

    logic [Width-1:0] mem [Depth];
    logic [PtrW-1:0]  wr_ptr;
    logic [PtrW-1:0]  rd_ptr;
    logic [CntW-1:0]  count;
    logic             do_push;
    logic             do_pop;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    assign full    = (count == CntW'(Depth));
    assign pop_vld = (count != '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & pop_vld;
    assign pop_dat = mem[rd_ptr];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CntW'(1);
                2'b01:   count <= count - CntW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: the head is only consumed while pop_vld is high.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end
endmodule

module tlul_adapter_reg_pipe
    import tlul_pkg::*;
#(
    parameter int RegAw          = 8,
    parameter int RegDw          = 32,
    parameter int AccessLatency  = 0,
    parameter int MaxOutstanding = 2,
    localparam int RegBw         = RegDw / 8,
    localparam int CntW          = $clog2(MaxOutstanding + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  tl_h2d_t          tl_i,
    output tl_d2h_t          tl_o,
    output logic             re_o,
    output logic             we_o,
    output logic [RegAw-1:0] addr_o,
    output logic [RegDw-1:0] wdata_o,
    output logic [RegBw-1:0] be_o,
    input  logic             busy_i,
    input  logic [RegDw-1:0] rdata_i,
    input  logic             error_i,
    output logic [CntW-1:0]  outstanding_o
);
    localparam int AiW = top_pkg::TL_AIW;
    localparam int SzW = top_pkg::TL_SZW;

    // Parameter legality, checked at elaboration.
    if (RegDw != top_pkg::TL_DW) begin : g_chk_dw
        $error("tlul_adapter_reg_pipe: RegDw must equal top_pkg::TL_DW");
    end
    if ((AccessLatency < 0) || (AccessLatency > 3)) begin : g_chk_lat
        $error("tlul_adapter_reg_pipe: AccessLatency must be 0..3");
    end
    if ((MaxOutstanding < 1) || (MaxOutstanding > 4)) begin : g_chk_max
        $error("tlul_adapter_reg_pipe: MaxOutstanding must be 1..4");
    end
    if (RegAw > top_pkg::TL_AW) begin : g_chk_aw
        $error("tlul_adapter_reg_pipe: RegAw must not exceed TL_AW");
    end

    // Per-request information that travels alongside the register access.
    typedef struct packed {
        logic [AiW-1:0] source;
        logic [SzW-1:0] size;
        logic           is_read;
        logic           ierr;
    } meta_t;

    // One queued D-channel response.
    typedef struct packed {
        logic [2:0]       opcode;
        logic [AiW-1:0]   source;
        logic [SzW-1:0]   size;
        logic             error;
        logic [RegDw-1:0] data;
    } rsp_t;

    logic [CntW-1:0] cnt;
    logic            a_ready;
    logic            a_ack;
    logic            d_ack;
    logic            is_get;
    logic            is_put;
    logic            ierr;
    meta_t           meta_in;
    meta_t           cap_meta;
    logic            cap_vld;
    rsp_t            rsp_in;
    rsp_t            rsp_head;
    logic            rsp_vld;
    logic            fifo_full;
    logic            unused_sig;

    // ------------------------------------------------------------------
    // A channel: acceptance and classification
    // ------------------------------------------------------------------
    assign is_get = (tl_i.a_opcode == Get);
    assign is_put = (tl_i.a_opcode == PutFullData) | (tl_i.a_opcode == PutPartialData);

    // Misaligned Puts and unknown opcodes are accepted but answered with an error.
    assign ierr = is_put ? (tl_i.a_address[1:0] != 2'b00) : ~is_get;

    // busy_i only matters while a request is actually presented.
    assign a_ready = (cnt < CntW'(MaxOutstanding)) & ~(tl_i.a_valid & busy_i);
    assign a_ack   = tl_i.a_valid & a_ready;
    assign d_ack   = rsp_vld & tl_i.d_ready;

    assign re_o    = a_ack & is_get;
    assign we_o    = a_ack & is_put & ~ierr;
    assign wdata_o = RegDw'(tl_i.a_data);
    assign be_o    = RegBw'(tl_i.a_mask);

    if (RegAw > 2) begin : g_addr
        assign addr_o = {tl_i.a_address[RegAw-1:2], 2'b00};
    end else begin : g_addr_zero
        assign addr_o = '0;
    end

    // In-flight count covers the latency pipeline and the response FIFO together,
    // which is why the FIFO can never overflow.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt <= '0;
        end else if (a_ack && !d_ack) begin
            cnt <= cnt + CntW'(1);
        end else if (!a_ack && d_ack) begin
            cnt <= cnt - CntW'(1);
        end
    end

    assign outstanding_o = cnt;

    // ------------------------------------------------------------------
    // Metadata pipeline, aligned with the register read latency
    // ------------------------------------------------------------------
    always_comb begin
        meta_in         = '0;
        meta_in.source  = tl_i.a_source;
        meta_in.size    = tl_i.a_size;
        meta_in.is_read = is_get;
        meta_in.ierr    = ierr;
    end

    if (AccessLatency == 0) begin : g_no_pipe
        // rdata_i/error_i are valid in the strobe cycle itself.
        assign cap_vld  = a_ack;
        assign cap_meta = meta_in;
    end else begin : g_pipe
        logic  vld_q  [AccessLatency];
        meta_t meta_q [AccessLatency];

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                for (int i = 0; i < AccessLatency; i++) begin
                    vld_q[i]  <= 1'b0;
                    meta_q[i] <= '0;
                end
            end else begin
                vld_q[0]  <= a_ack;
                meta_q[0] <= meta_in;
                for (int i = 1; i < AccessLatency; i++) begin
                    vld_q[i]  <= vld_q[i-1];
                    meta_q[i] <= meta_q[i-1];
                end
            end
        end

        assign cap_vld  = vld_q[AccessLatency-1];
        assign cap_meta = meta_q[AccessLatency-1];
    end

    // ------------------------------------------------------------------
    // Response capture
    // ------------------------------------------------------------------
    always_comb begin
        rsp_in        = '0;
        rsp_in.opcode = cap_meta.is_read ? AccessAckData : AccessAck;
        rsp_in.source = cap_meta.source;
        rsp_in.size   = cap_meta.size;
        // error_i is meaningless when no strobe was issued, so ierr masks it.
        rsp_in.error  = cap_meta.ierr | (error_i & ~cap_meta.ierr);
        // Writes and failed accesses return all-ones rather than stale read data.
        if (!cap_meta.is_read || cap_meta.ierr || error_i) begin
            rsp_in.data = '1;
        end else begin
            rsp_in.data = rdata_i;
        end
    end

    fifo_sync #(
        .Width ($bits(rsp_t)),
        .Depth (MaxOutstanding)
    ) u_rsp_fifo (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .push     (cap_vld),
        .push_dat (rsp_in),
        .pop      (d_ack),
        .pop_vld  (rsp_vld),
        .pop_dat  (rsp_head),
        .full     (fifo_full)
    );

    // ------------------------------------------------------------------
    // D channel: fields are held at zero while nothing is queued
    // ------------------------------------------------------------------
    always_comb begin
        tl_o         = '0;
        tl_o.a_ready = a_ready;
        tl_o.d_valid = rsp_vld;
        if (rsp_vld) begin
            tl_o.d_opcode = rsp_head.opcode;
            tl_o.d_source = rsp_head.source;
            tl_o.d_size   = rsp_head.size;
            tl_o.d_error  = rsp_head.error;
            tl_o.d_data   = rsp_head.data;
        end
    end

    // Request fields with no role in a register access (param, user, upper address).
    assign unused_sig = ^{tl_i, fifo_full};
endmodule

// File: tb/tb_tlul_adapter_reg_pipe.sv
// Bench for tlul_adapter_reg_pipe: three instances (lat0/max2, lat2/max4, lat1/max2),
// each with a small register-block model and a per-instance expected-response queue.
module tb_tlul_adapter_reg_pipe;
    import tlul_pkg::*;

    typedef struct packed {
        logic [2:0]  op;
        logic [7:0]  src;
        logic [1:0]  size;
        logic        err;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          cyc = 0;
    int          tests = 0;
    int          fails = 0;

    tl_h2d_t     h2d     [3];
    tl_d2h_t     d2h     [3];
    logic        re      [3];
    logic        we      [3];
    logic [7:0]  addr    [3];
    logic [31:0] wdata   [3];
    logic [3:0]  be      [3];
    logic        busy    [3];
    logic [31:0] rdata   [3];
    logic        err     [3];
    logic        err_sel [3];
    logic [2:0]  outs    [3];

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic logic [31:0] reg_val(input logic [7:0] a);
        return {16'hA5A5, 12'h000, a[7:4]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference response for one request, derived from the request alone.
    function automatic exp_t model(input logic [2:0] op, input logic [7:0] a,
                                   input logic [7:0] src, input logic e);
        exp_t x;
        logic g, p, ie;
        g  = (op == 3'h4);
        p  = (op == 3'h0) || (op == 3'h1);
        ie = (p && (a[1:0] != 2'b00)) || (!g && !p);
        x.op   = g ? 3'h1 : 3'h0;
        x.src  = src;
        x.size = 2'd2;
        x.err  = ie | e;
        x.data = (!g || ie || e) ? 32'hFFFF_FFFF : reg_val({a[7:2], 2'b00});
        return x;
    endfunction

    task automatic push_exp(input int k, input exp_t x);
        case (k)
            0: q0.push_back(x);
            1: q1.push_back(x);
            default: q2.push_back(x);
        endcase
    endtask

    function automatic int qsize(input int k);
        case (k)
            0: return q0.size();
            1: return q1.size();
            default: return q2.size();
        endcase
    endfunction

    task automatic pop_check(input int k);
        exp_t    e;
        logic    got;
        tl_d2h_t d;
        d   = d2h[k];
        got = 1'b0;
        e   = '0;
        case (k)
            0: if (q0.size() > 0) begin e = q0.pop_front(); got = 1'b1; end
            1: if (q1.size() > 0) begin e = q1.pop_front(); got = 1'b1; end
            default: if (q2.size() > 0) begin e = q2.pop_front(); got = 1'b1; end
        endcase
        chk("rsp_was_expected", 32'(got), 32'd1);
        if (got) begin
            chk("d_opcode", 32'(d.d_opcode), 32'(e.op));
            chk("d_source", 32'(d.d_source), 32'(e.src));
            chk("d_size", 32'(d.d_size), 32'(e.size));
            chk("d_error", 32'(d.d_error), 32'(e.err));
            chk("d_data", d.d_data, e.data);
            chk("d_param_sink_user", 32'({d.d_param, d.d_sink, d.d_user}), 32'd0);
        end
    endtask

    for (genvar k = 0; k < 3; k++) begin : g_dut
        localparam int L  = (k == 0) ? 0 : ((k == 1) ? 2 : 1);
        localparam int M  = (k == 1) ? 4 : 2;
        localparam int OW = $clog2(M + 1);
        logic [OW-1:0] o;

        tlul_adapter_reg_pipe #(
            .RegAw          (8),
            .RegDw          (32),
            .AccessLatency  (L),
            .MaxOutstanding (M)
        ) u_dut (
            .clk_i         (clk),
            .rst_ni        (rst_n),
            .tl_i          (h2d[k]),
            .tl_o          (d2h[k]),
            .re_o          (re[k]),
            .we_o          (we[k]),
            .addr_o        (addr[k]),
            .wdata_o       (wdata[k]),
            .be_o          (be[k]),
            .busy_i        (busy[k]),
            .rdata_i       (rdata[k]),
            .error_i       (err[k]),
            .outstanding_o (o)
        );
        assign outs[k] = 3'(o);

        // Register block model: answers L cycles after each strobe, garbage otherwise.
        if (L == 0) begin : g_rm0
            assign rdata[k] = re[k] ? reg_val(addr[k]) : 32'hDEAD_BEEF;
            assign err[k]   = (re[k] | we[k]) & err_sel[k];
        end else begin : g_rmn
            logic       pv [L];
            logic [7:0] pa [L];
            logic       pe [L];
            always @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < L; i++) pv[i] <= 1'b0;
                end else begin
                    pv[0] <= re[k] | we[k];
                    pa[0] <= addr[k];
                    pe[0] <= err_sel[k];
                    for (int i = 1; i < L; i++) begin
                        pv[i] <= pv[i-1];
                        pa[i] <= pa[i-1];
                        pe[i] <= pe[i-1];
                    end
                end
            end
            assign rdata[k] = pv[L-1] ? reg_val(pa[L-1]) : 32'hDEAD_BEEF;
            assign err[k]   = pv[L-1] & pe[L-1];
        end

        // D-channel monitor.
        int   rise_cyc = -1;
        logic prev_vld = 1'b0;
        int   nrsp = 0;
        always @(negedge clk) begin
            if (!rst_n) begin
                prev_vld = 1'b0;
            end else begin
                if (d2h[k].d_valid && !prev_vld) rise_cyc = cyc;
                prev_vld = d2h[k].d_valid;
                if (d2h[k].d_valid && h2d[k].d_ready) begin
                    pop_check(k);
                    nrsp++;
                end
            end
        end
    end

    // Present one request and hold it until accepted (bounded).
    task automatic send(input int k, input logic [2:0] op, input logic [7:0] a,
                        input logic [7:0] src, input logic [31:0] wd, input logic [3:0] m,
                        input logic e, output int acc_cyc, output int stalls,
                        output logic re_s, output logic we_s);
        logic done;
        h2d[k].a_valid   = 1'b1;
        h2d[k].a_opcode  = op;
        h2d[k].a_address = {24'h0, a};
        h2d[k].a_source  = src;
        h2d[k].a_size    = 2'd2;
        h2d[k].a_data    = wd;
        h2d[k].a_mask    = m;
        err_sel[k]       = e;
        done = 1'b0; stalls = 0; acc_cyc = -1; re_s = 1'b0; we_s = 1'b0;
        for (int n = 0; n < 64 && !done; n++) begin
            @(negedge clk);
            if (d2h[k].a_ready) begin
                done    = 1'b1;
                acc_cyc = cyc;
                re_s    = re[k];
                we_s    = we[k];
                if (re[k] || we[k]) chk("addr_o", 32'(addr[k]), 32'({a[7:2], 2'b00}));
                if (we[k]) begin
                    chk("wdata_o", wdata[k], wd);
                    chk("be_o", 32'(be[k]), 32'(m));
                end
                push_exp(k, model(op, a, src, e));
            end else begin
                stalls++;
            end
            @(posedge clk); #1;
        end
        h2d[k].a_valid = 1'b0;
        chk("accept_within_budget", 32'(done), 32'd1);
    endtask

    task automatic drain(input int k);
        for (int n = 0; n < 200 && qsize(k) != 0; n++) @(posedge clk);
        #1;
        chk("drain_queue_empty", 32'(qsize(k)), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   acc, acc0, stl, tot, c0;
        logic rs, ws;

        for (int k = 0; k < 3; k++) begin
            h2d[k]         = '0;
            h2d[k].d_ready = 1'b1;
            busy[k]        = 1'b0;
            err_sel[k]     = 1'b0;
        end

        // ---------------- reset state ----------------
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk("rst_d_valid", 32'(d2h[k].d_valid), 32'd0);
            chk("rst_outstanding", 32'(outs[k]), 32'd0);
            chk("rst_a_ready", 32'(d2h[k].a_ready), 32'd1);
            chk("rst_strobes", 32'({re[k], we[k]}), 32'd0);
            chk("rst_d_fields", 32'({d2h[k].d_opcode, d2h[k].d_source, d2h[k].d_size, d2h[k].d_error}), 32'd0);
            chk("rst_d_data", d2h[k].d_data, 32'd0);
        end
        h2d[0].a_valid = 1'b1;
        busy[0]        = 1'b1;
        #1;
        chk("rst_a_ready_busy", 32'(d2h[0].a_ready), 32'd0);
        h2d[0].a_valid = 1'b0;
        busy[0]        = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // ---------------- basic latency: lat0/max2 ----------------
        send(0, 3'h4, 8'h10, 8'd3, 32'h0, 4'hF, 1'b0, acc, stl, rs, ws);
        chk("basic_re", 32'(rs), 32'd1);
        chk("basic_we", 32'(ws), 32'd0);
        drain(0);
        chk("basic_dvalid_cycle", 32'(g_dut[0].rise_cyc), 32'(acc + 1));

        // ---------------- streaming: lat2/max4 ----------------
        tot = 0;
        for (int i = 0; i < 8; i++) begin
            send(1, 3'h4, 8'(8'h10 * (i + 1)), 8'(i), 32'h0, 4'hF, 1'b0, acc, stl, rs, ws);
            if (i == 0) acc0 = acc;
            tot += stl;
        end
        chk("stream_no_stall", 32'(tot), 32'd0);
        drain(1);
        chk("stream_first_dvalid", 32'(g_dut[1].rise_cyc), 32'(acc0 + 3));
        chk("stream_rsp_count", 32'(g_dut[1].nrsp), 32'd8);

        // ---------------- backpressure: lat1/max2 ----------------
        h2d[2].d_ready = 1'b0;
        send(2, 3'h0, 8'h20, 8'd1, 32'h1111_2222, 4'hF, 1'b0, acc, stl, rs, ws);
        chk("bp_we_first", 32'(ws), 32'd1);
        send(2, 3'h1, 8'h24, 8'd2, 32'h3333_4444, 4'h3, 1'b0, acc, stl, rs, ws);
        h2d[2].a_valid   = 1'b1;
        h2d[2].a_opcode  = 3'h0;
        h2d[2].a_address = 32'h28;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("bp_a_ready_low", 32'(d2h[2].a_ready), 32'd0);
            chk("bp_outstanding", 32'(outs[2]), 32'd2);
            chk("bp_no_strobe", 32'({re[2], we[2]}), 32'd0);
            @(posedge clk); #1;
        end
        h2d[2].d_ready = 1'b1;
        c0 = cyc;
        send(2, 3'h0, 8'h28, 8'd3, 32'h5555_6666, 4'hF, 1'b0, acc, stl, rs, ws);
        chk("bp_accept_after_dack", 32'(acc), 32'(c0 + 1));
        drain(2);

        // ---------------- error paths: lat1/max2 ----------------
        send(2, 3'h0, 8'h13, 8'd4, 32'hCAFE_0000, 4'hF, 1'b0, acc, stl, rs, ws);
        chk("misaligned_put_no_we", 32'({rs, ws}), 32'd0);
        send(2, 3'h4, 8'h30, 8'd5, 32'h0, 4'hF, 1'b1, acc, stl, rs, ws);
        chk("err_get_re", 32'(rs), 32'd1);
        send(2, 3'h5, 8'h40, 8'd6, 32'h0, 4'hF, 1'b0, acc, stl, rs, ws);
        chk("bad_opcode_no_strobe", 32'({rs, ws}), 32'd0);
        send(2, 3'h1, 8'h44, 8'd7, 32'h0BAD_F00D, 4'h6, 1'b1, acc, stl, rs, ws);
        chk("err_put_we", 32'(ws), 32'd1);
        send(2, 3'h4, 8'h53, 8'd8, 32'h0, 4'hF, 1'b0, acc, stl, rs, ws);
        drain(2);

        // ---------------- busy_i: lat0/max2 ----------------
        h2d[0].a_valid   = 1'b1;
        h2d[0].a_opcode  = 3'h4;
        h2d[0].a_address = 32'h60;
        busy[0]          = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("busy_a_ready_low", 32'(d2h[0].a_ready), 32'd0);
            chk("busy_no_strobe", 32'({re[0], we[0]}), 32'd0);
            @(posedge clk); #1;
        end
        busy[0] = 1'b0;
        c0 = cyc;
        send(0, 3'h4, 8'h60, 8'd9, 32'h0, 4'hF, 1'b0, acc, stl, rs, ws);
        chk("busy_accept_cycle", 32'(acc), 32'(c0));
        chk("busy_re", 32'(rs), 32'd1);
        drain(0);

        // ---------------- reset mid-operation: lat2/max4 ----------------
        h2d[1].d_ready = 1'b0;
        send(1, 3'h4, 8'h70, 8'd10, 32'h0, 4'hF, 1'b0, acc, stl, rs, ws);
        send(1, 3'h4, 8'h74, 8'd11, 32'h0, 4'hF, 1'b0, acc, stl, rs, ws);
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("pre_rst_d_valid", 32'(d2h[1].d_valid), 32'd1);
        chk("pre_rst_outstanding", 32'(outs[1]), 32'd2);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_d_valid", 32'(d2h[1].d_valid), 32'd0);
        chk("mid_rst_outstanding", 32'(outs[1]), 32'd0);
        q1.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n          = 1'b1;
        h2d[1].d_ready = 1'b1;
        @(posedge clk); #1;
        send(1, 3'h4, 8'h80, 8'd12, 32'h0, 4'hF, 1'b0, acc, stl, rs, ws);
        drain(1);
        chk("post_rst_dvalid_cycle", 32'(g_dut[1].rise_cyc), 32'(acc + 3));

        // ---------------- quiescence ----------------
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk("final_d_valid", 32'(d2h[k].d_valid), 32'd0);
            chk("final_outstanding", 32'(outs[k]), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/tlul_adapter_reg_pipe.md
# tlul_adapter_reg_pipe

Pipelined TL-UL device adapter that converts TL-UL A-channel requests into a single-cycle register strobe interface and returns D-channel responses. It has a configurable register-file read latency and supports up to `MaxOutstanding` in-flight requests through a response FIFO. It sits between a crossbar port and a generated or hand-written register block. It replaces the single-outstanding adapter wherever back-to-back register traffic or multi-cycle register reads are needed.

## Interface
- `RegAw`, 8: register address width; `addr_o` is forced word-aligned (bits [1:0] = 0). If RegAw<=2, `addr_o` is all zeros.
- `RegDw`, 32: data width; must equal `top_pkg::TL_DW` (elaboration assertion).
- `AccessLatency`, 0: cycles from the `re_o`/`we_o` strobe to the cycle where `rdata_i`/`error_i` are valid. Legal values are 0..3.
- `MaxOutstanding`, 2: maximum accepted but not yet D-acked requests. Legal values are 1..4; this is also the response FIFO depth.
- `clk_i` in 1: clock.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `tl_i` in `tl_h2d_t`: TL-UL host request.
- `tl_o` out `tl_d2h_t`: TL-UL device response.
- `re_o` out 1: read strobe, high only in the A-accept cycle.
- `we_o` out 1: write strobe, high only in the A-accept cycle.
- `addr_o` out RegAw: `{a_address[RegAw-1:2],2'b00}`.
- `wdata_o` out RegDw: equals `a_data`.
- `be_o` out RegDw/8: equals `a_mask`.
- `busy_i` in 1: register block cannot take the presented request; backpressures A.
- `rdata_i` in RegDw: read data, valid AccessLatency cycles after the strobe.
- `error_i` in 1: access error, valid AccessLatency cycles after the strobe.
- `outstanding_o` out $clog2(MaxOutstanding+1): current in-flight count (debug/DV).

## Operation
- `cnt` tracks accepted requests not yet D-acked.
  - It increments on `a_ack = a_valid & a_ready`.
  - It decrements on `d_ack = d_valid & d_ready`.
  - If both happen in the same cycle, it is unchanged.
- `a_ready = (cnt < MaxOutstanding) & ~(a_valid & busy_i)`. `a_ready` does not depend on `d_ready`.
- Request classification:
  - Opcode Get gives `re_o = a_ack`.
  - Opcode PutFullData or PutPartialData gives `we_o = a_ack`, unless there is an internal error.
- Internal error (`ierr`) is set in either case:
  - a Put with `a_address[1:0] != 0`;
  - any other opcode.
  
  On `ierr` the request is accepted, no strobe is issued, and the response carries `d_error = 1`.
- Metadata {source, size, opcode class, ierr} enters a shift pipeline `AccessLatency` stages deep. When `AccessLatency = 0` there are no stages and the metadata goes directly to the capture point.
- When the metadata reaches the capture point, a response entry is pushed into the FIFO with these fields:
  - `d_opcode`: AccessAckData for Get, otherwise AccessAck.
  - `d_source`, `d_size`: the saved values.
  - `d_error = ierr | (error_i & ~ierr)`.
  - `d_data = '1` if it is a write, if `ierr` is set, or if `error_i` is high; otherwise `d_data = rdata_i`.
- FIFO overflow is impossible by construction, because total occupancy (pipeline + FIFO) is at most `cnt` ≤ MaxOutstanding.
- D channel:
  - `d_valid` = FIFO not empty, and it presents the head entry.
  - The head is popped on `d_ack`.
  - `d_param`, `d_sink`, `d_user` are 0.
- Reset values:
  - `cnt = 0`; pipeline and FIFO are empty.
  - `d_valid = 0`, `d_opcode = AccessAck`, `d_source = 0`, `d_size = 0`, `d_data = 0`, `d_error = 0`.
  - `outstanding_o = 0`.
  - `a_ready = ~(a_valid & busy_i)`.
  - `re_o`/`we_o` are combinational and are 0 while no request is accepted.
- Assertion of reset mid-operation discards all in-flight entries immediately; no D response is produced for them.

## Timing
- Strobes are in the A-accept cycle T.
- Data and error are sampled at the end of cycle T+AccessLatency.
- `d_valid` rises at T+AccessLatency+1 at the earliest.
- Full throughput (one request per cycle with `d_ready = 1`) requires MaxOutstanding ≥ AccessLatency+2. Otherwise `a_ready` drops periodically.
- With `d_ready = 0`, at most MaxOutstanding requests are accepted, then `a_ready = 0` until a `d_ack`.
- `a_ready` stays 0 in the cycle of the `d_ack` that frees the slot; it rises the cycle after.
- `busy_i` is only honoured while `a_valid = 1`.
- Response order equals request order.

## Test plan
- Basic latency (AccessLatency=0, Max=2): Get to 0x10 with `rdata_i = 0xA5A5_0001`.
  - `re_o` pulses in the accept cycle.
  - Next cycle: `d_valid = 1`, AccessAckData, data 0xA5A5_0001, `d_error = 0`.
- Streaming (AccessLatency=2, Max=4): 8 back-to-back Gets with sources 0..7 and `d_ready = 1`.
  - `a_ready` is never 0.
  - Responses arrive in order 0..7, first `d_valid` 3 cycles after the first accept.
- Backpressure (AccessLatency=1, Max=2): `d_ready = 0`, 3 Puts issued.
  - Two are accepted, `outstanding_o = 2`, third stalls.
  - Raise `d_ready`: third is accepted one cycle after the first `d_ack`.
  - All responses are AccessAck with `d_data = 0xFFFF_FFFF`.
- Error paths:
  - Put to 0x13: no `we_o`, `d_error = 1`.
  - Get with `error_i = 1` at capture: `d_error = 1`, `d_data = 0xFFFF_FFFF`.
  - Opcode 3'h5: `d_error = 1`, no strobe.
- `busy_i` held 3 cycles with `a_valid = 1`: no accept, no strobe. Accept happens in the first cycle with `busy_i = 0`.
- Reset asserted with 2 in flight: `d_valid` goes 0 immediately and `outstanding_o = 0`. After release, a new Get completes normally.
